// File: rtl/locked_reg_pkg.sv
// Shared types and constants for the lock-protected register write controller.
package locked_reg_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        ARMED    = 2'd1,
        UNLOCKED = 2'd2,
        FROZEN   = 2'd3
    } lock_state_e;

    localparam int unsigned ADDR_KEY  = 0;
    localparam int unsigned ADDR_CTRL = 1;
    localparam int unsigned REG_BASE  = 2;

    localparam logic [31:0] KEY0_DEFAULT = 32'hA5A5_0001;
    localparam logic [31:0] KEY1_DEFAULT = 32'h5A5A_0002;

endpackage

// File: rtl/lock_window_timer.sv
// Loadable down-counter; expire flags the edge on which a running count steps 1 -> 0.
module lock_window_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             run,
    output logic             expire
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (run && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Not gated by load so the owner can use it when choosing the next state.
    assign expire = run && (count_q == WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/locked_reg_ctrl.sv
// Write-access controller: two-key timed unlock, freeze, and violation accounting
// in front of a bank of lock-protected config registers.
module locked_reg_ctrl
    import locked_reg_pkg::*;
#(
    parameter int unsigned       REG_COUNT     = 4,
    parameter int unsigned       DATA_W        = 32,
    parameter int unsigned       ADDR_W        = $clog2(REG_COUNT + 2),
    parameter logic [DATA_W-1:0] KEY0          = DATA_W'(KEY0_DEFAULT),
    parameter logic [DATA_W-1:0] KEY1          = DATA_W'(KEY1_DEFAULT),
    parameter int unsigned       KEY_TIMEOUT   = 16,
    parameter int unsigned       UNLOCK_WINDOW = 64,
    parameter int unsigned       VCNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_data,
    output logic                 resp_valid,
    output logic                 resp_err,
    output logic [REG_COUNT-1:0] reg_write_en,
    output logic [DATA_W-1:0]    reg_data_in,
    output logic [1:0]           lock_state,
    output logic [VCNT_W-1:0]    viol_count,
    output logic                 irq_violation
);

    localparam int unsigned TIMER_MAX = (KEY_TIMEOUT > UNLOCK_WINDOW) ? KEY_TIMEOUT : UNLOCK_WINDOW;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [ADDR_W:0] MAX_ADDR = (ADDR_W + 1)'(REG_COUNT + 1);

    lock_state_e          state_q, state_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_err_q, resp_err_d;
    logic [REG_COUNT-1:0] write_en_q, write_en_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [VCNT_W-1:0]    viol_count_q, viol_count_d;
    logic                 irq_q, irq_d;

    logic                 err;
    logic                 addr_key, addr_ctrl, addr_bad;
    logic [ADDR_W-1:0]    reg_idx;
    logic                 timer_load, timer_run, timer_expire;
    logic [TIMER_W-1:0]   timer_load_val;

    assign addr_key  = (req_addr == ADDR_W'(ADDR_KEY));
    assign addr_ctrl = (req_addr == ADDR_W'(ADDR_CTRL));
    assign addr_bad  = ({1'b0, req_addr} > MAX_ADDR);
    assign reg_idx   = req_addr - ADDR_W'(REG_BASE);
    assign timer_run = (state_q == ARMED) || (state_q == UNLOCKED);

    always_comb begin
        state_d    = state_q;
        err        = 1'b0;
        write_en_d = '0;
        data_d     = '0;
        if (req_valid) begin
            case (state_q)
                LOCKED: begin
                    if (addr_key && (req_data == KEY0)) state_d = ARMED;
                    else                                err     = 1'b1;
                end
                ARMED: begin
                    if (addr_key && (req_data == KEY1)) begin
                        state_d = UNLOCKED;
                    end else begin
                        err     = 1'b1;
                        state_d = LOCKED;
                    end
                end
                UNLOCKED: begin
                    if (addr_bad) begin
                        err = 1'b1;
                    end else if (addr_key) begin
                        state_d = LOCKED;
                    end else if (addr_ctrl) begin
                        if (req_data[0]) state_d = FROZEN;
                    end else begin
                        write_en_d = REG_COUNT'(1) << reg_idx;
                        data_d     = req_data;
                    end
                end
                default: err = 1'b1;
            endcase
        end
        // Window expiry only relocks when the request on this edge did not move the FSM;
        // a request in the final cycle is still honoured above.
        if (timer_expire && (state_d == state_q)) state_d = LOCKED;

        timer_load     = (state_d != state_q);
        timer_load_val = '0;
        if (state_d == ARMED)         timer_load_val = TIMER_W'(KEY_TIMEOUT);
        else if (state_d == UNLOCKED) timer_load_val = TIMER_W'(UNLOCK_WINDOW);

        resp_valid_d = req_valid;
        resp_err_d   = err;
        irq_d        = err;
        viol_count_d = viol_count_q;
        if (err && (viol_count_q != '1)) viol_count_d = viol_count_q + 1'b1;
    end

    lock_window_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_load_val),
        .run      (timer_run),
        .expire   (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOCKED;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            write_en_q   <= '0;
            data_q       <= '0;
            viol_count_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            write_en_q   <= write_en_d;
            data_q       <= data_d;
            viol_count_q <= viol_count_d;
            irq_q        <= irq_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign reg_write_en  = write_en_q;
    assign reg_data_in   = data_q;
    assign lock_state    = state_q;
    assign viol_count    = viol_count_q;
    assign irq_violation = irq_q;

endmodule
